// File: rtl/mult_seq8.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mult_seq8 (with rca16 ripple-carry adder)
// Function : 8x8 unsigned shift-and-add multiplier, one partial product per cycle
// Revision : 1.0
//------------------------------------------------------------------------------

module rca16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [16:0] w_c;

    assign w_c[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[16];
endmodule

module mult_seq8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        busy,
    output logic        done,
    output logic [15:0] P
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_CNT = 3'd7;

    state_t      r_state;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;
    logic [15:0] r_p;
    logic        r_busy;
    logic        r_done;

    logic [15:0] w_addend;
    logic [15:0] w_sum;
    logic        w_cout_unused;

    assign w_addend = r_mplier[0] ? r_mcand : 16'h0000;

    // Product never exceeds 16'hFE01, so the carry out is never needed.
    rca16 u_rca16 (
        .i_a    (r_acc),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= 16'h0000;
            r_mplier <= 8'h00;
            r_acc    <= 16'h0000;
            r_cnt    <= 3'd0;
            r_p      <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_acc    <= w_sum;
                    r_mcand  <= {r_mcand[14:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[7:1]};
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == c_LAST_CNT) begin
                        r_p     <= w_sum;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {8'h00, A};
                        r_mplier <= B;
                        r_acc    <= 16'h0000;
                        r_cnt    <= 3'd0;
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign P    = r_p;
endmodule

`default_nettype wire

// File: tb/tb_mult_seq8.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mult_seq8
// Function : scoreboard bench for mult_seq8; inputs driven and outputs sampled
//            on the falling clock edge
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mult_seq8;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [15:0] P;

    int n_vec;
    int n_err;
    logic [15:0] exp_q[$];

    mult_seq8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start; returns positioned one falling edge later (k=1).
    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        A     = a;
        B     = b;
        start = 1'b1;
        prod  = 16'(a) * 16'(b);
        exp_q.push_back(prod);
        @(negedge clk);
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
    endtask

    // Walks falling edges until done (bounded), noting latency, busy and P stability.
    task automatic wait_done(input int k0, input logic [15:0] p_hold,
                             output int lat, output bit busy_ok, output bit stable_ok);
        lat       = k0;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (P !== p_hold)  stable_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b P=%h, required busy=0 done=0 P=0000", busy, done, P);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max;
        int lat; bit bok; bit sok; logic [15:0] e;
        pulse_start(8'hFF, 8'hFF);
        wait_done(1, 16'h0000, lat, bok, sok);
        e = exp_q.pop_front();
        n_vec++;
        if (lat !== 9 || !bok) begin
            n_err++;
            $display("FAIL max_latency: done at cycle %0d busy_ok=%0d, required cycle 9 busy_ok=1", lat, bok);
        end
        n_vec++;
        if (P !== e || busy !== 1'b0) begin
            n_err++;
            $display("FAIL max_product: P=%h busy=%b, required P=%h busy=0", P, busy, e);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || P !== 16'hFE01) begin
            n_err++;
            $display("FAIL max_after: done=%b busy=%b P=%h, required done=0 busy=0 P=fe01", done, busy, P);
        end
    endtask

    task automatic test_basic;
        int lat; bit bok; bit sok; logic [15:0] e;
        pulse_start(8'h80, 8'h01);
        wait_done(1, 16'hFE01, lat, bok, sok);
        e = exp_q.pop_front();
        n_vec++;
        if (P !== e || lat !== 9 || !sok) begin
            n_err++;
            $display("FAIL basic_80x01: P=%h lat=%0d stable=%0d, required P=%h lat=9 stable=1", P, lat, sok, e);
        end
        @(negedge clk);
        pulse_start(8'h00, 8'hA5);
        wait_done(1, 16'h0080, lat, bok, sok);
        e = exp_q.pop_front();
        n_vec++;
        if (P !== e || lat !== 9 || !bok || !sok) begin
            n_err++;
            $display("FAIL basic_zero: P=%h lat=%0d busy_ok=%0d stable=%0d, required P=%h lat=9 1 1", P, lat, bok, sok, e);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat; bit bok; bit sok; int extra; logic [15:0] e;
        pulse_start(8'h0C, 8'h0A);
        @(negedge clk);
        @(negedge clk);
        A     = 8'hFF;
        B     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, 16'h0000, lat, bok, sok);
        e = exp_q.pop_front();
        n_vec++;
        if (P !== e || lat !== 9 || !bok) begin
            n_err++;
            $display("FAIL ignore_start: P=%h lat=%0d busy_ok=%0d, required P=%h lat=9 busy_ok=1", P, lat, bok, e);
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_single_done: extra done=%0d busy=%b, required 0 and 0", extra, busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit bok; bit sok; logic [15:0] e;
        A     = 8'h03;
        B     = 8'h05;
        start = 1'b1;
        exp_q.push_back(16'h000F);
        @(negedge clk);
        for (int rep = 0; rep < 4; rep++) begin
            wait_done(1, (rep == 0) ? 16'h0078 : 16'h000F, lat, bok, sok);
            e = exp_q.pop_front();
            n_vec++;
            if (P !== e || lat !== 9 || !bok || !sok || busy !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_%0d: P=%h lat=%0d busy_ok=%0d stable=%0d busy=%b, required P=%h lat=9 1 1 busy=0",
                         rep, P, lat, bok, sok, busy, e);
            end
            if (rep < 3) exp_q.push_back(16'h000F);
            else         start = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: busy=%b done=%b, required 0 and 0", busy, done);
        end
    endtask

    task automatic test_async_reset;
        int lat; bit bok; bit sok; int extra; logic [15:0] e;
        pulse_start(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        n_vec++;
        if (P !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: P=%h busy=%b done=%b, required 0000 0 0", P, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", extra);
        end
        pulse_start(8'h12, 8'h34);
        wait_done(1, 16'h0000, lat, bok, sok);
        e = exp_q.pop_front();
        n_vec++;
        if (P !== e || lat !== 9 || !bok) begin
            n_err++;
            $display("FAIL post_reset: P=%h lat=%0d busy_ok=%0d, required P=%h lat=9 busy_ok=1", P, lat, bok, e);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat; bit bok; bit sok; int gap; logic [15:0] e; logic [15:0] hold;
        hold = P;
        for (int i = 0; i < 2000; i++) begin
            pulse_start(8'($urandom), 8'($urandom));
            wait_done(1, hold, lat, bok, sok);
            e = exp_q.pop_front();
            n_vec++;
            if (P !== e || lat !== 9 || !bok || !sok) begin
                n_err++;
                $display("FAIL random_%0d: P=%h lat=%0d busy_ok=%0d stable=%0d, required P=%h lat=9 1 1",
                         i, P, lat, bok, sok, e);
            end
            hold = e;
            gap  = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                n_vec++;
                if (done !== 1'b0 || P !== hold) begin
                    n_err++;
                    $display("FAIL random_idle_%0d: done=%b P=%h, required done=0 P=%h", i, done, P, hold);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_max();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
